// File: rtl/cpu_pkg.sv
// Shared opcodes, FSM states and instruction field helpers
// for the parametrised multi-cycle core.
package cpu_pkg;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_AND = 4'h3;
  localparam logic [3:0] OP_OR  = 4'h4;
  localparam logic [3:0] OP_XOR = 4'h5;
  localparam logic [3:0] OP_SHL = 4'h6;
  localparam logic [3:0] OP_SHR = 4'h7;
  localparam logic [3:0] OP_LDI = 4'h8;
  localparam logic [3:0] OP_LD  = 4'h9;
  localparam logic [3:0] OP_ST  = 4'hA;
  localparam logic [3:0] OP_JMP = 4'hB;
  localparam logic [3:0] OP_JZ  = 4'hC;
  localparam logic [3:0] OP_JC  = 4'hD;
  localparam logic [3:0] OP_CMP = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  typedef enum logic [2:0] {
    S_FETCH,
    S_FETCH_IMM,
    S_EXEC,
    S_MEM,
    S_HALT
  } state_t;

  // Fields sit at the top of the word: opcode, rd, rs.
  function automatic logic [3:0] op_of(
    input logic [63:0] w, input int dw);
    return 4'(w >> (dw - 4));
  endfunction

  function automatic logic [7:0] rd_of(
    input logic [63:0] w, input int dw, input int aw);
    return 8'((w >> (dw - 4 - aw)) & ((64'd1 << aw) - 64'd1));
  endfunction

  function automatic logic [7:0] rs_of(
    input logic [63:0] w, input int dw, input int aw);
    return 8'((w >> (dw - 4 - 2 * aw)) & ((64'd1 << aw) - 64'd1));
  endfunction

  function automatic logic has_imm(input logic [3:0] op);
    return op inside {OP_LDI, OP_JMP, OP_JZ, OP_JC};
  endfunction

endpackage

// File: rtl/cpu_regfile.sv
// Register file: two asynchronous read ports,
// one synchronous write port, cleared on reset.
module cpu_regfile #(
  parameter int DATA_W = 8,
  parameter int REG_AW = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [REG_AW-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [REG_AW-1:0] ra1,
  input  logic [REG_AW-1:0] ra2,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2
);

  localparam int NREG = 2 ** REG_AW;

  logic [DATA_W-1:0] regs [NREG];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (we) begin
      regs[waddr] <= wdata;
    end
  end

  assign rd1 = regs[ra1];
  assign rd2 = regs[ra2];

endmodule

// File: rtl/cpu_core_bus.sv
// Multi-cycle RISC core with carry flag and a single
// req/ack memory port shared by instruction and data.
module cpu_core_bus
  import cpu_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 8,
  parameter int REG_AW   = 2,
  parameter int RESET_PC = 0
) (
  input  logic              clk,
  input  logic              reset,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              halt,
  output logic              retire,
  output logic [ADDR_W-1:0] pc_out,
  output logic [1:0]        flags_out
);

  state_t            state;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_inc;
  logic [ADDR_W-1:0] exec_pc;
  logic [DATA_W-1:0] ir;
  logic [DATA_W-1:0] imm;
  logic              c_flag;
  logic              z_flag;

  logic [3:0]        op;
  logic [REG_AW-1:0] rd;
  logic [REG_AW-1:0] rs;
  logic [DATA_W-1:0] a;
  logic [DATA_W-1:0] b;
  logic [DATA_W-1:0] res;
  logic              cout;
  logic              alu_wr;
  logic              flag_wr;
  logic              taken;
  logic              rf_we;
  logic [DATA_W-1:0] rf_wdata;

  assign op = op_of(64'(ir), DATA_W);
  assign rd = REG_AW'(rd_of(64'(ir), DATA_W, REG_AW));
  assign rs = REG_AW'(rs_of(64'(ir), DATA_W, REG_AW));

  assign pc_inc    = pc + ADDR_W'(1);
  assign pc_out    = pc;
  assign flags_out = {c_flag, z_flag};

  cpu_regfile #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_rf (
    .clk   (clk),
    .reset (reset),
    .we    (rf_we),
    .waddr (rd),
    .wdata (rf_wdata),
    .ra1   (rd),
    .ra2   (rs),
    .rd1   (a),
    .rd2   (b)
  );

  always_comb begin
    res  = '0;
    cout = 1'b0;
    case (op)
      OP_ADD: {cout, res} = {1'b0, a} + {1'b0, b};
      OP_SUB, OP_CMP: begin
        res  = a - b;
        cout = b > a;
      end
      OP_AND: res = a & b;
      OP_OR:  res = a | b;
      OP_XOR: res = a ^ b;
      OP_SHL: begin
        res  = a << 1;
        cout = a[DATA_W-1];
      end
      OP_SHR: begin
        res  = a >> 1;
        cout = a[0];
      end
      default: ;
    endcase
  end

  assign alu_wr  = op inside {[OP_ADD:OP_SHR]};
  assign flag_wr = alu_wr || (op == OP_CMP);
  assign taken   = (op == OP_JMP) ||
                   (op == OP_JZ && z_flag) ||
                   (op == OP_JC && c_flag);
  assign exec_pc = taken ? ADDR_W'(imm) : pc;

  always_comb begin
    rf_we    = 1'b0;
    rf_wdata = res;
    if (state == S_EXEC && alu_wr) begin
      rf_we = 1'b1;
    end else if (state == S_EXEC && op == OP_LDI) begin
      rf_we    = 1'b1;
      rf_wdata = imm;
    end else if (state == S_MEM && op == OP_LD && mem_ack) begin
      rf_we    = 1'b1;
      rf_wdata = mem_rdata;
    end
  end

  // Bus outputs are registered; the first fetch after reset
  // spends one cycle raising mem_req.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_FETCH;
      pc        <= ADDR_W'(RESET_PC);
      ir        <= '0;
      imm       <= '0;
      c_flag    <= 1'b0;
      z_flag    <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      halt      <= 1'b0;
      retire    <= 1'b0;
    end else begin
      retire <= 1'b0;
      case (state)
        S_FETCH: begin
          if (!mem_req) begin
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= pc;
          end else if (mem_ack) begin
            ir <= mem_rdata;
            pc <= pc_inc;
            if (has_imm(op_of(64'(mem_rdata), DATA_W))) begin
              state    <= S_FETCH_IMM;
              mem_addr <= pc_inc;
            end else begin
              state   <= S_EXEC;
              mem_req <= 1'b0;
            end
          end
        end
        S_FETCH_IMM: begin
          if (mem_ack) begin
            imm     <= mem_rdata;
            pc      <= pc_inc;
            state   <= S_EXEC;
            mem_req <= 1'b0;
          end
        end
        S_EXEC: begin
          state    <= S_FETCH;
          mem_req  <= 1'b1;
          mem_we   <= 1'b0;
          mem_addr <= exec_pc;
          pc       <= exec_pc;
          retire   <= 1'b1;
          if (flag_wr) begin
            c_flag <= cout;
            z_flag <= (res == '0);
          end
          if (op == OP_LD || op == OP_ST) begin
            state     <= S_MEM;
            mem_addr  <= ADDR_W'(b);
            mem_we    <= (op == OP_ST);
            mem_wdata <= a;
            retire    <= 1'b0;
          end else if (op == OP_HLT) begin
            state   <= S_HALT;
            mem_req <= 1'b0;
            halt    <= 1'b1;
          end
        end
        S_MEM: begin
          if (mem_ack) begin
            state    <= S_FETCH;
            mem_we   <= 1'b0;
            mem_addr <= pc;
            retire   <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_core_bus.sv
// Directed bench: three core configurations, each with
// its own memory model and hand-computed expectations.
module tb_cpu_core_bus;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // 8-bit core, variable-latency memory
  logic       rst8;
  logic       req8, we8, ack8, halt8, ret8;
  logic [7:0] addr8, wdata8, rdata8, pc8;
  logic [1:0] fl8;
  logic [7:0] mem8 [256];
  logic [7:0] img8 [256];
  int         dly8 = 0;
  int         wcnt8 = 0;
  bit         rnd8 = 0;
  bit         stall8 = 0;

  cpu_core_bus #(
    .DATA_W(8), .ADDR_W(8), .REG_AW(2), .RESET_PC(0)
  ) u8 (
    .clk(clk), .reset(rst8),
    .mem_req(req8), .mem_we(we8),
    .mem_addr(addr8), .mem_wdata(wdata8),
    .mem_ack(ack8), .mem_rdata(rdata8),
    .halt(halt8), .retire(ret8),
    .pc_out(pc8), .flags_out(fl8)
  );

  assign ack8 = req8 && !(stall8 && addr8 == 8'h40)
                && (wcnt8 >= dly8);
  assign rdata8 = mem8[addr8];

  // Reset reloads the program image and drops any
  // transfer that was in flight.
  always @(posedge clk or posedge rst8) begin
    if (rst8) begin
      wcnt8 <= 0;
      dly8  <= rnd8 ? int'($urandom_range(3, 0)) : 0;
      for (int i = 0; i < 256; i++) mem8[i] <= img8[i];
    end else if (req8 && !ack8) begin
      wcnt8 <= wcnt8 + 1;
    end else begin
      wcnt8 <= 0;
      if (ack8) begin
        dly8 <= rnd8 ? int'($urandom_range(3, 0)) : 0;
        if (we8) mem8[addr8] <= wdata8;
      end
    end
  end

  logic [17:0] snap8;
  bit          pend8 = 0;
  int          viol8 = 0;
  int          waits8 = 0;
  always @(posedge clk) begin
    if (pend8 && !rst8 && {req8, we8, addr8, wdata8} != snap8)
      viol8++;
    if (req8 && !ack8 && !rst8) waits8++;
    pend8 <= req8 && !ack8 && !rst8;
    snap8 <= {req8, we8, addr8, wdata8};
  end

  int         cyc8 = 0;
  int         rq8[$];
  logic [1:0] fq8[$];
  always @(negedge clk) begin
    cyc8++;
    if (ret8) begin
      rq8.push_back(cyc8);
      fq8.push_back(fl8);
    end
  end

  // ADDR_W=4 core, zero-wait memory
  logic       rst4;
  logic       req4, we4, halt4, ret4;
  logic [3:0] addr4, pc4;
  logic [7:0] wdata4, rdata4;
  logic [1:0] fl4;
  logic [7:0] mem4 [16];
  logic [3:0] aq4[$];

  cpu_core_bus #(
    .DATA_W(8), .ADDR_W(4), .REG_AW(2), .RESET_PC(2)
  ) u4 (
    .clk(clk), .reset(rst4),
    .mem_req(req4), .mem_we(we4),
    .mem_addr(addr4), .mem_wdata(wdata4),
    .mem_ack(1'b1), .mem_rdata(rdata4),
    .halt(halt4), .retire(ret4),
    .pc_out(pc4), .flags_out(fl4)
  );

  assign rdata4 = mem4[addr4];
  always @(posedge clk) if (req4 && !rst4) aq4.push_back(addr4);

  // 16-bit, 8-register core, zero-wait memory
  logic        rst16;
  logic        req16, we16, halt16, ret16;
  logic [7:0]  addr16, pc16;
  logic [15:0] wdata16, rdata16;
  logic [1:0]  fl16;
  logic [15:0] mem16 [256];

  cpu_core_bus #(
    .DATA_W(16), .ADDR_W(8), .REG_AW(3), .RESET_PC(16)
  ) u16 (
    .clk(clk), .reset(rst16),
    .mem_req(req16), .mem_we(we16),
    .mem_addr(addr16), .mem_wdata(wdata16),
    .mem_ack(1'b1), .mem_rdata(rdata16),
    .halt(halt16), .retire(ret16),
    .pc_out(pc16), .flags_out(fl16)
  );

  assign rdata16 = mem16[addr16];

  task automatic clr8();
    for (int i = 0; i < 256; i++) img8[i] = 8'h00;
  endtask

  task automatic run8(input string tag);
    int n = 0;
    rst8 = 1'b1;
    repeat (2) @(negedge clk);
    rst8 = 1'b0;
    while (!halt8 && n < 400) begin
      @(negedge clk);
      n++;
    end
    check({tag, " halt"}, 32'(halt8), 1);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int b;
    int n;
    rst8 = 1'b1;
    rst4 = 1'b1;
    rst16 = 1'b1;

    // LDI r0,5; LDI r1,3; ADD r0,r1; HLT
    clr8();
    img8[0] = 8'h80; img8[1] = 8'h05;
    img8[2] = 8'h84; img8[3] = 8'h03;
    img8[4] = 8'h11; img8[5] = 8'hF0;
    repeat (2) @(negedge clk);
    check("rst req", 32'(req8), 0);
    check("rst addr", 32'(addr8), 0);
    check("rst pc", 32'(pc8), 0);
    check("rst halt", 32'(halt8), 0);
    check("rst retire", 32'(ret8), 0);
    check("rst pc16", 32'(pc16), 32'h10);
    b = rq8.size();
    run8("t1");
    check("t1 r0", 32'(u8.u_rf.regs[0]), 8);
    check("t1 flags", 32'(fl8), 0);
    check("t1 pc", 32'(pc8), 6);
    check("t1 retires", 32'(rq8.size() - b), 4);
    if (rq8.size() - b == 4) begin
      check("t1 ldi lat", 32'(rq8[b+1] - rq8[b]), 3);
      check("t1 add lat", 32'(rq8[b+2] - rq8[b+1]), 2);
      check("t1 hlt lat", 32'(rq8[b+3] - rq8[b+2]), 2);
    end
    repeat (3) @(negedge clk);
    check("t1 halt sticky", 32'(halt8), 1);
    check("t1 halt no req", 32'(req8), 0);

    // carry/borrow and untaken conditional jumps
    clr8();
    img8[0]  = 8'h80; img8[1]  = 8'hFF;
    img8[2]  = 8'h84; img8[3]  = 8'h01;
    img8[4]  = 8'h11;
    img8[5]  = 8'hE4;
    img8[6]  = 8'hD0; img8[7]  = 8'h20;
    img8[8]  = 8'hC0; img8[9]  = 8'h20;
    img8[10] = 8'h88; img8[11] = 8'h77;
    img8[12] = 8'hF0;
    img8[32] = 8'hF0;
    b = rq8.size();
    run8("t2");
    check("t2 r0", 32'(u8.u_rf.regs[0]), 0);
    check("t2 r2", 32'(u8.u_rf.regs[2]), 32'h77);
    check("t2 pc", 32'(pc8), 13);
    check("t2 retires", 32'(rq8.size() - b), 8);
    if (rq8.size() - b == 8) begin
      check("t2 add flags", 32'(fq8[b+2]), 2'b11);
      check("t2 cmp flags", 32'(fq8[b+3]), 2'b00);
    end

    // store then load under random ack delays
    clr8();
    rnd8 = 1;
    img8[0] = 8'h88; img8[1] = 8'h40;
    img8[2] = 8'h84; img8[3] = 8'hA5;
    img8[4] = 8'hA6;
    img8[5] = 8'h9E;
    img8[6] = 8'hF0;
    b = rq8.size();
    n = viol8;
    run8("t3");
    check("t3 mem", 32'(mem8[8'h40]), 32'hA5);
    check("t3 r3", 32'(u8.u_rf.regs[3]), 32'hA5);
    check("t3 stable", 32'(viol8 - n), 0);
    check("t3 waited", 32'(waits8 > 0), 1);
    check("t3 retires", 32'(rq8.size() - b), 5);
    rnd8 = 0;

    // PC wrap on an immediate fetch at the top address
    for (int i = 0; i < 16; i++) mem4[i] = 8'h00;
    mem4[2]  = 8'hB0; mem4[3] = 8'h0F;
    mem4[15] = 8'h80;
    mem4[0]  = 8'h5A;
    mem4[1]  = 8'hF0;
    b = aq4.size();
    @(negedge clk);
    rst4 = 1'b0;
    n = 0;
    while (!halt4 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("t4 halt", 32'(halt4), 1);
    check("t4 r0", 32'(u4.u_rf.regs[0]), 32'h5A);
    check("t4 pc", 32'(pc4), 2);
    check("t4 fetches", 32'(aq4.size() - b), 5);
    if (aq4.size() - b == 5) begin
      check("t4 a0", 32'(aq4[b]), 2);
      check("t4 a1", 32'(aq4[b+1]), 3);
      check("t4 a2", 32'(aq4[b+2]), 15);
      check("t4 a3", 32'(aq4[b+3]), 0);
      check("t4 a4", 32'(aq4[b+4]), 1);
    end

    // 16-bit SUB borrow and SHL carry-out
    for (int i = 0; i < 256; i++) mem16[i] = 16'h0000;
    mem16[8'h10] = 16'h8E00; mem16[8'h11] = 16'h0003;
    mem16[8'h12] = 16'h8C00; mem16[8'h13] = 16'h0005;
    mem16[8'h14] = 16'h2F80;
    mem16[8'h15] = 16'h8A00; mem16[8'h16] = 16'h8000;
    mem16[8'h17] = 16'h6A00;
    mem16[8'h18] = 16'hF000;
    @(negedge clk);
    rst16 = 1'b0;
    n = 0;
    while (!halt16 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("t5 halt", 32'(halt16), 1);
    check("t5 r7", 32'(u16.u_rf.regs[7]), 32'hFFFE);
    check("t5 r5", 32'(u16.u_rf.regs[5]), 0);
    check("t5 flags", 32'(fl16), 2'b11);
    check("t5 pc", 32'(pc16), 32'h19);

    // reset while a load is stalled on the bus
    clr8();
    img8[0] = 8'h88; img8[1] = 8'h40;
    img8[2] = 8'h9E;
    img8[3] = 8'hF0;
    stall8 = 1;
    rst8 = 1'b1;
    repeat (2) @(negedge clk);
    rst8 = 1'b0;
    n = 0;
    while (!(req8 && addr8 == 8'h40) && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("t6 mem pending", 32'(req8 && addr8 == 8'h40), 1);
    #2 rst8 = 1'b1;
    #1;
    check("t6 req", 32'(req8), 0);
    check("t6 addr", 32'(addr8), 0);
    check("t6 we", 32'(we8), 0);
    check("t6 wdata", 32'(wdata8), 0);
    check("t6 pc", 32'(pc8), 0);
    check("t6 flags", 32'(fl8), 0);
    check("t6 retire", 32'(ret8), 0);
    check("t6 r2", 32'(u8.u_rf.regs[2]), 0);
    @(negedge clk);
    stall8 = 0;
    rst8 = 1'b0;
    n = 0;
    while (!req8 && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("t6 refetch req", 32'(req8), 1);
    check("t6 refetch addr", 32'(addr8), 0);
    check("t6 refetch we", 32'(we8), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
